// File: rtl/str_pkg.sv
// Definitions shared by the stream width-conversion blocks: lane emission order,
// remaining-beat state names and a helper that sizes lane counters.
package str_pkg;

    typedef enum logic {
        LANE_LSB_FIRST = 1'b0,
        LANE_MSB_FIRST = 1'b1
    } lane_order_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FINAL = 2'd2
    } rem_state_e;

    // Width needed to hold a lane count from 0 up to and including nb.
    function automatic int cnt_width(input int nb);
        return $clog2(nb + 1);
    endfunction

endpackage

// File: rtl/str_unpack.sv
// Wide-to-narrow stream unpacker: splits each upstream word into up_cnt lanes and emits them
// one per downstream beat. Define STR_UNPACK_MSB_FIRST_EN to emit the highest valid lane first.
module str_unpack
    import str_pkg::*;
#(
    parameter int  DATA_UP_WIDTH = 32,
    parameter int  DATA_DN_WIDTH = 8,
    localparam int DATA_NB       = DATA_UP_WIDTH / DATA_DN_WIDTH,
    localparam int CNT_WIDTH     = cnt_width(DATA_NB)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_UP_WIDTH-1:0] up_data,
    input  logic [CNT_WIDTH-1:0]     up_cnt,
    input  logic                     up_last,
    input  logic                     up_val,
    output logic                     up_rdy,
    output logic [DATA_DN_WIDTH-1:0] dn_data,
    output logic                     dn_last,
    output logic                     dn_val,
    input  logic                     dn_rdy
);

`ifdef STR_UNPACK_MSB_FIRST_EN
    localparam lane_order_e LANE_ORDER = LANE_MSB_FIRST;
`else
    localparam lane_order_e LANE_ORDER = LANE_LSB_FIRST;
`endif

    localparam logic [CNT_WIDTH-1:0] NB_C = CNT_WIDTH'(DATA_NB);

    // MSB-first: move lane n-1 to the top so emission always pulls from the same end.
    function automatic logic [DATA_UP_WIDTH-1:0] align(input logic [DATA_UP_WIDTH-1:0] w,
                                                       input logic [CNT_WIDTH-1:0]     n);
        if (LANE_ORDER == LANE_MSB_FIRST)
            return w << (DATA_DN_WIDTH * (DATA_NB - int'(n)));
        return w;
    endfunction

    function automatic logic [DATA_DN_WIDTH-1:0] head(input logic [DATA_UP_WIDTH-1:0] w);
        if (LANE_ORDER == LANE_MSB_FIRST)
            return w[DATA_UP_WIDTH-1 -: DATA_DN_WIDTH];
        return w[DATA_DN_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_UP_WIDTH-1:0] advance(input logic [DATA_UP_WIDTH-1:0] w);
        if (LANE_ORDER == LANE_MSB_FIRST)
            return w << DATA_DN_WIDTH;
        return w >> DATA_DN_WIDTH;
    endfunction

    logic [DATA_UP_WIDTH-1:0] shreg_q, shreg_d, aligned;
    logic [CNT_WIDTH-1:0]     rem_q, rem_d, n_cnt;
    logic                     last_q, last_d;
    logic                     primed_q;
    logic [DATA_DN_WIDTH-1:0] dn_data_q, dn_data_d;
    logic                     dn_last_q, dn_last_d;
    logic                     dn_val_q, dn_val_d;
    logic                     up_fire, dn_fire;
    rem_state_e               state;

    assign state   = (rem_q == '0) ? ST_EMPTY :
                     (rem_q == CNT_WIDTH'(1)) ? ST_FINAL : ST_SHIFT;
    assign up_rdy  = primed_q & (~dn_val_q | ((state == ST_FINAL) & dn_rdy));
    assign up_fire = up_val & up_rdy;
    assign dn_fire = dn_val_q & dn_rdy;
    assign n_cnt   = (up_cnt > NB_C) ? NB_C : up_cnt;
    assign aligned = align(up_data, n_cnt);

    always_comb begin
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        last_d    = last_q;
        dn_data_d = dn_data_q;
        dn_last_d = dn_last_q;
        dn_val_d  = dn_val_q;
        // A load wins over a plain consume: up_fire implies any pending final beat is taken now.
        if (up_fire) begin
            last_d = up_last;
            if (n_cnt == '0) begin
                shreg_d   = '0;
                rem_d     = up_last ? CNT_WIDTH'(1) : '0;
                dn_data_d = '0;
                dn_last_d = up_last;
                dn_val_d  = up_last;
            end else begin
                shreg_d   = advance(aligned);
                rem_d     = n_cnt;
                dn_data_d = head(aligned);
                dn_last_d = up_last & (n_cnt == CNT_WIDTH'(1));
                dn_val_d  = 1'b1;
            end
        end else if (dn_fire) begin
            if (state == ST_SHIFT) begin
                shreg_d   = advance(shreg_q);
                rem_d     = rem_q - CNT_WIDTH'(1);
                dn_data_d = head(shreg_q);
                dn_last_d = last_q & (rem_q == CNT_WIDTH'(2));
            end else begin
                rem_d     = '0;
                dn_last_d = 1'b0;
                dn_val_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            rem_q     <= '0;
            last_q    <= 1'b0;
            primed_q  <= 1'b0;
            dn_data_q <= '0;
            dn_last_q <= 1'b0;
            dn_val_q  <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            rem_q     <= rem_d;
            last_q    <= last_d;
            primed_q  <= 1'b1;
            dn_data_q <= dn_data_d;
            dn_last_q <= dn_last_d;
            dn_val_q  <= dn_val_d;
        end
    end

    assign dn_data = dn_data_q;
    assign dn_last = dn_last_q;
    assign dn_val  = dn_val_q;

endmodule

// File: tb/tb_str_unpack.sv
// Bench for str_unpack (32-bit words, 8-bit lanes): directed table, corner sequences and
// randomized traffic against a lane-list reference model. Honors STR_UNPACK_MSB_FIRST_EN.
module tb_str_unpack;

    logic        clk;
    logic        rst;
    logic [31:0] up_data;
    logic [2:0]  up_cnt;
    logic        up_last;
    logic        up_val;
    logic        up_rdy;
    logic [7:0]  dn_data;
    logic        dn_last;
    logic        dn_val;
    logic        dn_rdy;

    str_unpack #(.DATA_UP_WIDTH(32), .DATA_DN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_cnt(up_cnt), .up_last(up_last), .up_val(up_val), .up_rdy(up_rdy),
        .dn_data(dn_data), .dn_last(dn_last), .dn_val(dn_val), .dn_rdy(dn_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic rnd_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: a word becomes an ordered list of lane values pushed on a queue.
    logic [8:0] exp_q[$];

    task automatic model_push(input logic [31:0] w, input logic [2:0] c, input logic l);
        int n;
        int idx;
        n = (int'(c) > 4) ? 4 : int'(c);
        if (n == 0) begin
            if (l) exp_q.push_back({8'h00, 1'b1});
        end else begin
            for (int i = 0; i < n; i++) begin
`ifdef STR_UNPACK_MSB_FIRST_EN
                idx = n - 1 - i;
`else
                idx = i;
`endif
                exp_q.push_back({8'(w >> (8 * idx)), l && (i == n - 1)});
            end
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the handshakes the next rising edge will commit.
    logic       hold_q = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;
    logic [8:0] mon_e;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_val",  int'(dn_val),  1);
                chk("hold_data", int'(dn_data), int'(hold_data));
                chk("hold_last", int'(dn_last), int'(hold_last));
            end
            hold_q    = dn_val && !dn_rdy;
            hold_data = dn_data;
            hold_last = dn_last;
            if (dn_val && dn_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mon_extra_beat: got beat %02h, required no beat", dn_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mon_data", int'(dn_data), int'(mon_e[8:1]));
                    chk("mon_last", int'(dn_last), int'(mon_e[0]));
                end
            end
            if (up_val && up_rdy) model_push(up_data, up_cnt, up_last);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) dn_rdy = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] d, input logic [2:0] c, input logic l);
        int   t;
        logic hs;
        t = 0;
        @(posedge clk);
        #1;
        up_data = d;
        up_cnt  = c;
        up_last = l;
        up_val  = 1'b1;
        do begin
            @(negedge clk);
            hs = up_rdy;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 50);
        if (!hs) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word %08h got no up_rdy, required acceptance within 50 cycles", d);
        end
        up_val = 1'b0;
    endtask

    logic [7:0] g_data[$];
    logic       g_last[$];
    logic       g_uprdy[$];
    int         g_cyc[$];
    logic       g_uprdy0;

    task automatic collect(input int ncyc);
        g_data.delete();
        g_last.delete();
        g_uprdy.delete();
        g_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) g_uprdy0 = up_rdy;
            if (dn_val && dn_rdy) begin
                g_data.push_back(dn_data);
                g_last.push_back(dn_last);
                g_uprdy.push_back(up_rdy);
                g_cyc.push_back(c);
            end
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        last;
        int          nb;
        logic [31:0] beats;
        logic        elast;
    } vec_t;

    vec_t       vec[7];
    logic [63:0] bb_exp;
    logic [31:0] tg_exp;
    logic [7:0]  rs_first;
    int          t;

    initial begin
        rst     = 1'b0;
        up_data = '0;
        up_cnt  = '0;
        up_last = 1'b0;
        up_val  = 1'b0;
        dn_rdy  = 1'b1;

`ifdef STR_UNPACK_MSB_FIRST_EN
        vec[0] = '{32'h44332211, 3'd4, 1'b1, 4, 32'h11223344, 1'b1};
        vec[1] = '{32'hAABBCCDD, 3'd2, 1'b1, 2, 32'h0000DDCC, 1'b1};
        vec[2] = '{32'h12345678, 3'd7, 1'b0, 4, 32'h78563412, 1'b0};
        vec[6] = '{32'h0BADF00D, 3'd3, 1'b0, 3, 32'h000DF0AD, 1'b0};
        bb_exp   = 64'h5566778811223344;
        tg_exp   = 32'hAABBCCDD;
        rs_first = 8'h0A;
`else
        vec[0] = '{32'h44332211, 3'd4, 1'b1, 4, 32'h44332211, 1'b1};
        vec[1] = '{32'hAABBCCDD, 3'd2, 1'b1, 2, 32'h0000CCDD, 1'b1};
        vec[2] = '{32'h12345678, 3'd7, 1'b0, 4, 32'h12345678, 1'b0};
        vec[6] = '{32'h0BADF00D, 3'd3, 1'b0, 3, 32'h00ADF00D, 1'b0};
        bb_exp   = 64'h8877665544332211;
        tg_exp   = 32'hDDCCBBAA;
        rs_first = 8'h0D;
`endif
        vec[3] = '{32'h55667788, 3'd0, 1'b1, 1, 32'h00000000, 1'b1};
        vec[4] = '{32'h99999999, 3'd0, 1'b0, 0, 32'h00000000, 1'b0};
        vec[5] = '{32'hCAFEBABE, 3'd1, 1'b1, 1, 32'h000000BE, 1'b1};

        // Reset state, then priming on the first edge after release.
        @(negedge clk);
        chk("rst_dn_val",  int'(dn_val),  0);
        chk("rst_dn_last", int'(dn_last), 0);
        chk("rst_dn_data", int'(dn_data), 0);
        chk("rst_up_rdy",  int'(up_rdy),  0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("unprimed_up_rdy", int'(up_rdy), 0);
        @(negedge clk);
        chk("primed_up_rdy", int'(up_rdy), 1);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            send(vec[v].data, vec[v].cnt, vec[v].last);
            collect(6);
            chk($sformatf("v%0d_nbeats", v), g_data.size(), vec[v].nb);
            if (vec[v].nb == 0) chk($sformatf("v%0d_up_rdy", v), int'(g_uprdy0), 1);
            for (int i = 0; i < g_data.size() && i < vec[v].nb; i++) begin
                chk($sformatf("v%0d_b%0d_data", v, i), int'(g_data[i]), int'(vec[v].beats[8*i +: 8]));
                chk($sformatf("v%0d_b%0d_last", v, i), int'(g_last[i]),
                    int'(vec[v].elast && (i == vec[v].nb - 1)));
                chk($sformatf("v%0d_b%0d_cycle", v, i), g_cyc[i], i);
                if (i == vec[v].nb - 1) chk($sformatf("v%0d_final_up_rdy", v), int'(g_uprdy[i]), 1);
            end
        end

        // Two words back to back: eight contiguous beats.
        fork
            begin
                send(32'h44332211, 3'd4, 1'b0);
                send(32'h88776655, 3'd4, 1'b1);
            end
            collect(14);
        join
        chk("b2b_nbeats", g_data.size(), 8);
        for (int i = 0; i < g_data.size() && i < 8; i++) begin
            chk($sformatf("b2b_b%0d_data", i), int'(g_data[i]), int'(bb_exp[8*i +: 8]));
            chk($sformatf("b2b_b%0d_gap", i), g_cyc[i] - g_cyc[0], i);
        end

        // Downstream ready toggling 1010: beats held until taken, order intact.
        fork
            send(32'hDDCCBBAA, 3'd4, 1'b1);
            begin
                for (int c = 0; c < 14; c++) begin
                    @(posedge clk);
                    #1;
                    dn_rdy = ~dn_rdy;
                end
                dn_rdy = 1'b1;
            end
            collect(16);
        join
        chk("tgl_nbeats", g_data.size(), 4);
        for (int i = 0; i < g_data.size() && i < 4; i++)
            chk($sformatf("tgl_b%0d_data", i), int'(g_data[i]), int'(tg_exp[8*i +: 8]));

        // Reset after the second beat: nothing residual, next word restarts cleanly.
        dn_rdy = 1'b1;
        send(32'h44332211, 3'd4, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_dn_val",  int'(dn_val),  0);
        chk("midrst_dn_data", int'(dn_data), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_up_rdy", int'(up_rdy), 1);
        collect(6);
        chk("midrst_residual", g_data.size(), 0);
        send(32'h0A0B0C0D, 3'd4, 1'b1);
        collect(6);
        chk("midrst_next_nbeats", g_data.size(), 4);
        if (g_data.size() > 0) chk("midrst_next_first", int'(g_data[0]), int'(rs_first));

        // Randomized traffic with random downstream stalls.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        dn_rdy = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_dn_val", int'(dn_val), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
